// File: rtl/seq_chunk_add_sub_pkg.sv
// Shared definitions for the chunked multi-cycle adder/subtractor:
// FSM state encoding and helpers that derive chunk count and counter width.
package seq_chunk_add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of CHUNK-wide slices in a WIDTH-wide operand.
    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Chunk counter width; kept at least one bit so NCHUNK=1 still has a counter.
    function automatic int calc_cnt_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/seq_chunk_add_sub_chunk_adder.sv
// Combinational CHUNK-bit ripple full adder; the parametrised form of the
// original fixed 8-bit adder. One slice of the sequential carry chain.
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < CHUNK; gi++) begin : g_bit
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[CHUNK];

endmodule

// File: rtl/seq_chunk_add_sub.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are processed CHUNK bits
// per cycle, LSB chunk first, through a registered carry. Subtraction is done
// as a + ~b + (1 - cin), so cout=1 in subtract mode means "no borrow".
module seq_chunk_add_sub
    import seq_chunk_add_sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int CW     = calc_cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

    generate
        if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_params
            $error("seq_chunk_add_sub: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] sum_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             out_valid_reg;

    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a    (a_sh_reg[CHUNK-1:0]),
        .b    (b_sh_reg[CHUNK-1:0]),
        .cin  (carry_reg),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    // New result chunk enters the accumulator from the MSB end, so after
    // NCHUNK steps the first (LSB) chunk has reached bit 0.
    generate
        if (NCHUNK == 1) begin : g_acc_single
            assign acc_next = chunk_sum;
        end else begin : g_acc_multi
            assign acc_next = {chunk_sum, acc_reg[WIDTH-1:CHUNK]};
        end
    endgenerate

    // Operands are only taken while idle; no pipelining of operations.
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;

    // Control FSM, operand shift registers, carry chain and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            acc_reg       <= '0;
            sum_reg       <= '0;
            cnt_reg       <= '0;
            carry_reg     <= 1'b0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= sub ? ~b : b;
                        carry_reg <= cin ^ sub;
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    a_sh_reg  <= a_sh_reg >> CHUNK;
                    b_sh_reg  <= b_sh_reg >> CHUNK;
                    acc_reg   <= acc_next;
                    carry_reg <= chunk_cout;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_CNT) begin
                        // The top chunk of each operand sits in the low slice
                        // now, so its MSB is the operand sign bit.
                        sum_reg       <= acc_next;
                        cout_reg      <= chunk_cout;
                        ovf_reg       <= (a_sh_reg[CHUNK-1] == b_sh_reg[CHUNK-1]) &&
                                         (chunk_sum[CHUNK-1] != a_sh_reg[CHUNK-1]);
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_chunk_add_sub.sv
// Directed bench for seq_chunk_add_sub: a 32/8 instance and an 8/8 instance.
module tb_seq_chunk_add_sub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        cin8 = 1'b0;
    logic        sub8 = 1'b0;
    logic        out_valid8;
    logic        out_ready8 = 1'b0;
    logic [7:0]  sum8;
    logic        cout8;
    logic        ovf8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_chunk_add_sub #(.WIDTH(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    seq_chunk_add_sub #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .sub       (sub8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .cout      (cout8),
        .ovf       (ovf8)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present an operation from IDLE, count edges to out_valid, scramble the
    // operand inputs after acceptance and check the result.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                          input logic tcin, input logic tsub,
                          input logic [31:0] esum, input logic ecout, input logic eovf);
        int lat;
        @(negedge clk);
        a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = ~tcin; sub = ~tsub;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd4);
        check({tag, " sum"}, 64'(sum), 64'(esum));
        check({tag, " cout"}, 64'(cout), 64'(ecout));
        check({tag, " ovf"}, 64'(ovf), 64'(eovf));
        $display("op %s: a=0x%08h b=0x%08h cin=%0d sub=%0d -> sum=0x%08h cout=%0d ovf=%0d lat=%0d",
                 tag, ta, tb_, tcin, tsub, sum, cout, ovf, lat);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " drain out_valid"}, 64'(out_valid), 64'd0);
        check({tag, " drain in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin : main
        int lat;
        logic [31:0] held;

        // Reset state
        #12;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset sum", 64'(sum), 64'd0);
        check("reset cout", 64'(cout), 64'd0);
        check("reset ovf", 64'(ovf), 64'd0);
        check("reset out_valid8", 64'(out_valid8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed add/sub vectors
        run_op("add47_28",  32'd47,         32'd28, 1'b0, 1'b0, 32'd75,         1'b0, 1'b0);
        run_op("addwrap",   32'hFFFF_FFFF,  32'd0,  1'b1, 1'b0, 32'd0,          1'b1, 1'b0);
        run_op("addovf",    32'h7FFF_FFFF,  32'd1,  1'b0, 1'b0, 32'h8000_0000,  1'b0, 1'b1);
        run_op("sub5_7",    32'd5,          32'd7,  1'b0, 1'b1, 32'hFFFF_FFFE,  1'b0, 1'b0);
        run_op("subovf",    32'h8000_0000,  32'd1,  1'b0, 1'b1, 32'h7FFF_FFFF,  1'b1, 1'b1);
        run_op("sub10_3b",  32'd10,         32'd3,  1'b1, 1'b1, 32'd6,          1'b1, 1'b0);
        run_op("addposovf", 32'h4000_0000,  32'h4000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

        // Back-pressure: hold result, ignore a second request
        @(negedge clk);
        a = 32'd100; b = 32'd23; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 32'd1; b = 32'd1;   // second request, held high throughout
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("stall latency", 64'(lat), 64'd4);
        check("stall first sum", 64'(sum), 64'd123);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("stall sum", 64'(sum), 64'd123);
            check("stall out_valid", 64'(out_valid), 64'd1);
            check("stall in_ready", 64'(in_ready), 64'd0);
        end
        $display("stall: held sum=%0d for 6 cycles with out_ready=0", sum);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release out_valid", 64'(out_valid), 64'd0);
        check("release in_ready", 64'(in_ready), 64'd1);
        check("release sum kept", 64'(sum), 64'd123);
        @(posedge clk);   // second request accepted here
        #1;
        in_valid = 1'b0;
        check("second accepted", 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("second latency", 64'(lat), 64'd4);
        check("second sum", 64'(sum), 64'd2);
        $display("second op: sum=%0d lat=%0d", sum, lat);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        a = 32'd1000; b = 32'd2000; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort out_valid", 64'(out_valid), 64'd0);
        check("abort sum", 64'(sum), 64'd0);
        check("abort cout", 64'(cout), 64'd0);
        check("abort in_ready", 64'(in_ready), 64'd1);
        $display("abort: reset mid-RUN, sum=%0d in_ready=%0d", sum, in_ready);
        @(negedge clk);
        rst_n = 1'b1;
        // No result from the aborted operation may appear
        held = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            held = held | 32'(out_valid);
        end
        check("abort no output", 64'(held), 64'd0);
        run_op("after_abort", 32'd255, 32'd255, 1'b0, 1'b0, 32'd510, 1'b0, 1'b0);

        // Single-chunk instance: 1-cycle latency
        @(negedge clk);
        a8 = 8'd255; b8 = 8'd255; cin8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        a8 = 8'h00; b8 = 8'h00;
        lat = 0;
        while (!out_valid8 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("w8 latency", 64'(lat), 64'd1);
        check("w8 sum", 64'(sum8), 64'd254);
        check("w8 cout", 64'(cout8), 64'd1);
        check("w8 ovf", 64'(ovf8), 64'd0);
        $display("w8 op: 255+255 -> sum=%0d cout=%0d ovf=%0d lat=%0d", sum8, cout8, ovf8, lat);
        @(negedge clk);
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0;
        check("w8 drain", 64'(out_valid8), 64'd0);

        @(negedge clk);
        a8 = 8'd127; b8 = 8'd1; cin8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("w8 ovf latency", 64'(lat), 64'd1);
        check("w8 ovf sum", 64'(sum8), 64'd128);
        check("w8 ovf cout", 64'(cout8), 64'd0);
        check("w8 ovf flag", 64'(ovf8), 64'd1);
        $display("w8 op: 127+1 -> sum=%0d cout=%0d ovf=%0d lat=%0d", sum8, cout8, ovf8, lat);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_chunk_add_sub.md
Name: seq_chunk_add_sub

Overview:
Parametrised multi-cycle adder/subtractor. Processes WIDTH-bit operands CHUNK bits per cycle, LSB chunk first, through a registered carry chain. Uses a valid/ready handshake on both sides. Generalises the team's fixed 8-bit ripple adder in three ways: width, a subtract mode, and a signed-overflow flag. Sits in the ALU datapath where area matters more than single-cycle latency.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of CHUNK
CHUNK, 8, bits processed per cycle; NCHUNK = WIDTH/CHUNK (CHUNK = WIDTH allowed, NCHUNK = 1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous reset, active low
in_valid  in  1  operands present
in_ready  out  1  block accepts operands (IDLE only)
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in (add) / borrow-in (sub)
sub  in  1  0: a+b+cin; 1: a-b-cin
out_valid  out  1  result valid, held until out_ready
out_ready  in  1  consumer accepts result
sum  out  WIDTH  result, modulo 2^WIDTH
cout  out  1  carry out of MSB; in sub mode 1 = no borrow
ovf  out  1  two's-complement signed overflow

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter 0, carry 0, sum=0, cout=0, ovf=0, out_valid=0, in_ready=1 once state is IDLE. Reset mid-RUN or in DONE discards the operation with no output.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid at a clock edge:
  - capture a and b_eff = sub ? ~b : b;
  - carry := cin ^ sub, so sub computes a + ~b + (1 - cin);
  - counter := 0; go to RUN.
- RUN: in_ready=0. Each cycle:
  - chunk adder adds the low CHUNK bits of the A and B_eff shift registers plus carry;
  - result chunk shifts into sum from the MSB end; operand registers shift right by CHUNK;
  - carry := chunk carry-out; counter++.
  - After chunk NCHUNK-1 completes: go to DONE, out_valid=1.
- Latency: out_valid rises exactly NCHUNK clock edges after the accepting edge. NCHUNK=1 gives 1 cycle.
- Output flags:
  - cout = final chunk carry-out;
  - ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), using the captured operands.
- DONE: sum/cout/ovf/out_valid held stable while out_ready=0. On out_ready=1: go to IDLE, out_valid=0. sum/cout/ovf retain their last values until the next result.
- No overlap: a new operation is accepted only from IDLE, so minimum spacing is NCHUNK+2 cycles. in_valid during RUN/DONE is ignored and the upstream must hold it.
- Operand inputs are sampled only at the accepting edge; later changes have no effect.
- Counter width is clog2(NCHUNK), minimum 1. Counter wraps are never reached, because the RUN exit happens at NCHUNK-1.
- No X on any output after reset.

Decomposition:
- Shared package/header holds:
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - NCHUNK derivation;
  - a WIDTH%CHUNK==0 elaboration check.
- One sub-module, chunk_adder #(CHUNK): combinational CHUNK-bit full adder with ports a, b, cin, sum, cout. It is the parametrised form of the existing 8-bit adder.
- FSM, shift registers, counter and flag logic live in the top.

Test Plan:
- WIDTH=32, CHUNK=8, sub=0, a=47, b=28, cin=0 -> after 4 cycles: sum=75, cout=0, ovf=0, out_valid=1.
- a=32'hFFFFFFFF, b=0, cin=1, sub=0 -> sum=0, cout=1, ovf=0. Then a=32'h7FFFFFFF, b=1, cin=0 -> sum=32'h80000000, cout=0, ovf=1.
- sub=1, a=5, b=7, cin=0 -> sum=32'hFFFFFFFE, cout=0, ovf=0. Then sub=1, a=32'h80000000, b=1 -> sum=32'h7FFFFFFF, cout=1, ovf=1.
- out_ready held 0 for 6 cycles after out_valid -> outputs stable, in_ready=0, a second in_valid is not accepted. out_ready=1 -> IDLE next cycle, then second operation accepted.
- rst_n pulsed low in RUN cycle 2 -> out_valid=0, sum=0, in_ready=1 immediately. The next operation, a=255, b=255, gives sum=510 with no residue from the aborted one.
- Instance with WIDTH=8, CHUNK=8, a=255, b=255, cin=0 -> 1-cycle latency, sum=8'd254, cout=1, ovf=0.
